comparator_seq: RTL and testbench
=================================

Name: comparator_seq

Overview:
- Parametrised, multi-cycle magnitude comparator for wide operands. It succeeds the single-cycle combinational comparator.
- It scans both operands MSB-first in CHUNK-bit slices, one slice per clock, and can interpret them as signed or unsigned.
- Results are registered, with a start/busy/done handshake.
- It sits in datapaths where a full-width single-cycle compare would limit timing.

Parameters:
MSB, 128, operand width in bits; must be an integer multiple of CHUNK
CHUNK, 16, slice width compared per cycle; NCHUNK = MSB/CHUNK (>= 2)
IDXW, $clog2(MSB/CHUNK), width of diff_chunk (derived localparam, not overridable)

Ports:
clk  input  1  clock, rising-edge
rst  input  1  asynchronous, active-high reset
start  input  1  request compare; accepted only when busy=0
signed_mode  input  1  1 = two's-complement compare, 0 = unsigned; captured with start
a  input  MSB  operand A; captured with start
b  input  MSB  operand B; captured with start
busy  output  1  compare in progress
done  output  1  one-cycle pulse: results updated
greater  output  1  a > b (registered, held)
less  output  1  a < b (registered, held)
equal  output  1  a == b (registered, held)
diff_chunk  output  IDXW  index of most significant differing slice; 0 when equal

Behaviour:
- Reset (async, any time, including mid-compare):
  - state=IDLE, busy=0, done=0.
  - greater=less=equal=0, diff_chunk=0.
  - Captured operands are discarded.
- FSM states are IDLE and COMPARE. busy = (state==COMPARE).
- IDLE + start at edge E0:
  - capture a, b, signed_mode into internal registers;
  - idx = NCHUNK-1; clear the found flag; state -> COMPARE.
- start while busy=1 is ignored; live a/b changes during a compare have no effect.
- COMPARE, each edge E1..: examine slice idx = bits [idx*CHUNK +: CHUNK].
  - Signed mode: the top slice (idx=NCHUNK-1) is compared with its MSB inverted (offset binary). All other slices are compared unsigned.
  - At the first slice where the values differ: latch gt/lt, latch diff_chunk = idx, set found.
  - Later slices never overwrite a found result.
- Finish at the edge where idx==0 is examined, or earlier per EARLY_EXIT_EN:
  - greater/less/equal and diff_chunk load the result;
  - equal=1, diff_chunk=0 if no slice differed;
  - done=1 for exactly the following cycle; state -> IDLE.
- Exactly one of greater/less/equal is 1 after the first completion. All three are 0 only between reset and the first done.
- Results hold until the next done.
- Back-to-back: start may be asserted in the done cycle (busy=0) and is accepted at that cycle's edge.
- Otherwise idx decrements by 1 per edge. No wrap: idx never goes below 0.

Optional Feature:
Macro COMPARATOR_SEQ_EARLY_EXIT_EN.
- Defined: COMPARE finishes at the edge where the first differing slice is found. Latency = 1 + (NCHUNK-1-diff_chunk) edges after E0 when unequal, and NCHUNK edges when equal.
- Undefined: fixed latency; done always rises at edge E_NCHUNK regardless of data.
- Result values are identical in both builds.

Test Plan:
1. Assert rst mid-compare (e.g. after E3 of a running compare) -> busy, done, greater, less, equal, diff_chunk all 0 immediately. Next start completes normally.
2. a=b=0, signed_mode=0, start -> done at E8 (MSB=128, CHUNK=16); equal=1, greater=less=0, diff_chunk=0. Same result in both builds.
3. a={4'hA,124'b0}, b={4'hD,124'b0}, unsigned -> less=1, diff_chunk=7. done at E1 with early exit, at E8 without.
4. a={4'hE,124'b0}, b={4'hC,124'b0}: unsigned -> greater=1. Then a={4'hE,124'b0}, b={4'h1,124'b0}: signed_mode=1 -> less=1, diff_chunk=7; the same operands with signed_mode=0 -> greater=1.
5. a=128'd5, b=128'd3, unsigned -> greater=1, diff_chunk=0, done at E8 in both builds. Changing a/b during busy does not alter the result.
6. Pulse start while busy -> ignored (busy stays high, result unaffected). Assert start again in the done cycle -> a new compare is accepted with zero idle gap.

Source files
------------

// File: rtl/comparator_seq_if.sv
// rtl/comparator_seq_if.sv - handshake and result bundle for comparator_seq
interface comparator_seq_if #(
  parameter int MSB   = 128,
  parameter int CHUNK = 16
) ();
  localparam int IDXW = $clog2(MSB / CHUNK);

  logic            start;
  logic            signed_mode;
  logic [MSB-1:0]  a;
  logic [MSB-1:0]  b;
  logic            busy;
  logic            done;
  logic            greater;
  logic            less;
  logic            equal;
  logic [IDXW-1:0] diff_chunk;

  modport master (
    output start, signed_mode, a, b,
    input  busy, done, greater, less, equal, diff_chunk
  );

  modport slave (
    input  start, signed_mode, a, b,
    output busy, done, greater, less, equal, diff_chunk
  );
endinterface

// File: rtl/comparator_seq.sv
// rtl/comparator_seq.sv - multi-cycle MSB-first sliced magnitude comparator
// Optional: COMPARATOR_SEQ_EARLY_EXIT_EN finishes at the first differing slice.
module comparator_seq #(
  parameter int MSB   = 128,
  parameter int CHUNK = 16
) (
  input logic             clk,
  input logic             rst,
  comparator_seq_if.slave bus
);
  localparam int NCHUNK = MSB / CHUNK;
  localparam int IDXW   = $clog2(NCHUNK);
  localparam logic [IDXW-1:0] IDX_TOP = IDXW'(NCHUNK - 1);
`ifdef COMPARATOR_SEQ_EARLY_EXIT_EN
  localparam bit EARLY_EXIT = 1'b1;
`else
  localparam bit EARLY_EXIT = 1'b0;
`endif

  typedef enum logic {IDLE, COMPARE} state_t;

  state_t          state, state_next;
  logic [MSB-1:0]  a_q, b_q;
  logic            smode_q;
  logic [IDXW-1:0] idx;
  logic            found, gt_f, lt_f;
  logic [IDXW-1:0] dc_f;
  logic            done_q, greater_q, less_q, equal_q;
  logic [IDXW-1:0] dc_q;

  logic [CHUNK-1:0] sa, sb;
  logic             slice_gt, slice_lt, hit, finish, accept;
  logic             res_gt, res_lt;
  logic [IDXW-1:0]  res_dc;

  always_comb begin
    sa = a_q[idx*CHUNK +: CHUNK];
    sb = b_q[idx*CHUNK +: CHUNK];
    // Offset binary on the top slice turns a signed compare into an unsigned one.
    if (smode_q && (idx == IDX_TOP)) begin
      sa[CHUNK-1] = ~sa[CHUNK-1];
      sb[CHUNK-1] = ~sb[CHUNK-1];
    end
    slice_gt = (sa > sb);
    slice_lt = (sa < sb);
    hit      = !found && (sa != sb);
    finish   = (idx == '0) || (EARLY_EXIT && hit);
    res_gt   = found ? gt_f : slice_gt;
    res_lt   = found ? lt_f : slice_lt;
    res_dc   = found ? dc_f : (hit ? idx : '0);
  end

  always_comb begin
    state_next = state;
    accept     = 1'b0;
    case (state)
      IDLE: begin
        if (bus.start) begin
          accept     = 1'b1;
          state_next = COMPARE;
        end
      end
      COMPARE: begin
        if (finish) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_q       <= '0;
      b_q       <= '0;
      smode_q   <= 1'b0;
      idx       <= '0;
      found     <= 1'b0;
      gt_f      <= 1'b0;
      lt_f      <= 1'b0;
      dc_f      <= '0;
      done_q    <= 1'b0;
      greater_q <= 1'b0;
      less_q    <= 1'b0;
      equal_q   <= 1'b0;
      dc_q      <= '0;
    end else begin
      done_q <= 1'b0;
      if (accept) begin
        a_q     <= bus.a;
        b_q     <= bus.b;
        smode_q <= bus.signed_mode;
        idx     <= IDX_TOP;
        found   <= 1'b0;
        gt_f    <= 1'b0;
        lt_f    <= 1'b0;
        dc_f    <= '0;
      end
      if (state == COMPARE) begin
        if (hit) begin
          found <= 1'b1;
          gt_f  <= slice_gt;
          lt_f  <= slice_lt;
          dc_f  <= idx;
        end
        if (finish) begin
          greater_q <= res_gt;
          less_q    <= res_lt;
          equal_q   <= !res_gt && !res_lt;
          dc_q      <= res_dc;
          done_q    <= 1'b1;
        end else begin
          idx <= idx - 1'b1;
        end
      end
    end
  end

  assign bus.busy       = (state == COMPARE);
  assign bus.done       = done_q;
  assign bus.greater    = greater_q;
  assign bus.less       = less_q;
  assign bus.equal      = equal_q;
  assign bus.diff_chunk = dc_q;
endmodule

// File: tb/tb_comparator_seq.sv
// tb/tb_comparator_seq.sv - directed table-driven bench for comparator_seq
module tb_comparator_seq;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   tests = 0;
  int   failed = 0;

  always #5 clk = ~clk;

  comparator_seq_if #(.MSB(128), .CHUNK(16)) bus ();
  comparator_seq #(.MSB(128), .CHUNK(16)) dut (.clk(clk), .rst(rst), .bus(bus));

  typedef struct {
    logic [127:0] a;
    logic [127:0] b;
    bit           sm;
    bit           g, l, e;
    int           dc;
  } vec_t;

  vec_t vecs[9];

  function automatic int exp_lat(bit eq, int dc);
`ifdef COMPARATOR_SEQ_EARLY_EXIT_EN
    return eq ? 8 : 1 + (7 - dc);
`else
    return 8;
`endif
  endfunction

  task automatic chk(string name, logic [127:0] act, logic [127:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic check_results(string tag, bit g, bit l, bit e, int dc);
    chk({tag, " greater"}, 128'(bus.greater), 128'(g));
    chk({tag, " less"}, 128'(bus.less), 128'(l));
    chk({tag, " equal"}, 128'(bus.equal), 128'(e));
    chk({tag, " diff_chunk"}, 128'(bus.diff_chunk), 128'(dc));
  endtask

  // Waits for done after E0; returns the number of edges from E0 to done.
  task automatic wait_done(output int n);
    n = 0;
    while (n < 20) begin
      @(posedge clk); #1;
      n++;
      if (bus.done) break;
    end
  endtask

  // Entered and left at #1 after a rising edge; scrambles a/b while busy.
  task automatic run_cmp(string tag, logic [127:0] a, logic [127:0] b, bit sm,
                         bit g, bit l, bit e, int dc);
    int n;
    bus.a = a; bus.b = b; bus.signed_mode = sm; bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    bus.a = {$urandom, $urandom, $urandom, $urandom};
    bus.b = {$urandom, $urandom, $urandom, $urandom};
    bus.signed_mode = ~sm;
    wait_done(n);
    chk({tag, " latency"}, 128'(n), 128'(exp_lat(e, dc)));
    check_results(tag, g, l, e, dc);
  endtask

  initial begin
    int n;
    bus.start = 1'b0; bus.signed_mode = 1'b0; bus.a = '0; bus.b = '0;

    vecs[0] = '{a: 128'd0, b: 128'd0, sm: 0, g: 0, l: 0, e: 1, dc: 0};
    vecs[1] = '{a: {4'hA, 124'b0}, b: {4'hD, 124'b0}, sm: 0, g: 0, l: 1, e: 0, dc: 7};
    vecs[2] = '{a: {4'hE, 124'b0}, b: {4'hC, 124'b0}, sm: 0, g: 1, l: 0, e: 0, dc: 7};
    vecs[3] = '{a: {4'hE, 124'b0}, b: {4'h1, 124'b0}, sm: 1, g: 0, l: 1, e: 0, dc: 7};
    vecs[4] = '{a: {4'hE, 124'b0}, b: {4'h1, 124'b0}, sm: 0, g: 1, l: 0, e: 0, dc: 7};
    vecs[5] = '{a: 128'd5, b: 128'd3, sm: 0, g: 1, l: 0, e: 0, dc: 0};
    vecs[6] = '{a: {128{1'b1}}, b: {{127{1'b1}}, 1'b0}, sm: 1, g: 1, l: 0, e: 0, dc: 0};
    vecs[7] = '{a: {63'b0, 1'b1, 64'b0}, b: 128'd0, sm: 1, g: 1, l: 0, e: 0, dc: 4};
    vecs[8] = '{a: 128'd0, b: {1'b1, 127'b0}, sm: 1, g: 1, l: 0, e: 0, dc: 7};

    #12;
    chk("reset busy", 128'(bus.busy), 128'(0));
    chk("reset done", 128'(bus.done), 128'(0));
    check_results("reset", 0, 0, 0, 0);
    rst = 1'b0;
    @(posedge clk); #1;

    for (int i = 0; i < 9; i++) begin
      run_cmp($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].sm,
              vecs[i].g, vecs[i].l, vecs[i].e, vecs[i].dc);
      @(posedge clk); #1;
      chk($sformatf("vec%0d done pulse", i), 128'(bus.done), 128'(0));
    end

    // Reset in the middle of a compare clears everything immediately.
    bus.a = 128'd5; bus.b = 128'd3; bus.signed_mode = 1'b0; bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    #1;
    chk("midrst busy", 128'(bus.busy), 128'(0));
    chk("midrst done", 128'(bus.done), 128'(0));
    check_results("midrst", 0, 0, 0, 0);
    rst = 1'b0;
    @(posedge clk); #1;
    run_cmp("after rst", {4'hA, 124'b0}, {4'hD, 124'b0}, 0, 0, 1, 0, 7);

    // Start while busy is ignored; start in the done cycle is taken at once.
    bus.a = 128'd5; bus.b = 128'd3; bus.signed_mode = 1'b0; bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    @(posedge clk); #1;
    bus.a = 128'd0; bus.b = 128'd9; bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    chk("ignored start busy", 128'(bus.busy), 128'(1));
    n = 2;
    while (n < 20 && !bus.done) begin
      @(posedge clk); #1;
      n++;
    end
    chk("ignored start latency", 128'(n), 128'(8));
    check_results("ignored start", 1, 0, 0, 0);
    bus.a = 128'd0; bus.b = 128'd0; bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    chk("b2b busy", 128'(bus.busy), 128'(1));
    wait_done(n);
    chk("b2b latency", 128'(n), 128'(8));
    check_results("b2b", 0, 0, 1, 0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global timeout: got running expected finished");
    $fatal(1);
  end
endmodule
